// File: rtl/shift_acc_pkg.sv
// Shared widths, limits and state encoding for the shift_acc accumulator.
package shift_acc_pkg;

  localparam int DATA_W    = 8;
  localparam int SHIFT_W   = 5;
  localparam int SUM_W     = 34;
  localparam int CNT_W     = 6;
  localparam int MAX_SHIFT = 26;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

endpackage

// File: rtl/shift_acc_shifter.sv
// Barrel shifter: zero-extends an 8-bit operand to 34 bits and shifts it left.
// Any bit that would land above bit 33 is dropped.
module shift_acc_shifter
  import shift_acc_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHIFT_W-1:0] shift,
  output logic [SUM_W-1:0]   aligned
);

  assign aligned = SUM_W'(data) << shift;

endmodule

// File: rtl/shift_acc.sv
// Frame accumulator: aligns each beat through the shifter, sums it into a
// 34-bit register, and holds the frame result behind a valid/ready handshake.
module shift_acc
  import shift_acc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUM_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_ovf,
  output logic               out_trunc
);

  state_t             state, state_next;
  logic [SUM_W-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic               trunc;
  logic [SUM_W-1:0]   aligned;
  logic [SUM_W:0]     add_full;
  logic [CNT_W-1:0]   count_inc;
  logic [CNT_W-1:0]   drop_pos;
  logic               trunc_now;
  logic               accept;

  shift_acc_shifter u_shifter (
    .data    (in_data),
    .shift   (in_shift),
    .aligned (aligned)
  );

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // Operand bits at positions >= drop_pos end up above bit 33 after the shift.
  assign drop_pos  = CNT_W'(SUM_W) - CNT_W'(in_shift);
  assign trunc_now = (in_shift > SHIFT_W'(MAX_SHIFT)) && ((in_data >> drop_pos) != '0);

  assign add_full  = {1'b0, acc} + {1'b0, aligned};
  assign count_inc = (count == '1) ? count : count + CNT_W'(1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACC: begin
        if (accept) state_next = in_last ? HOLD : ACC;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The first beat of a frame overwrites the previous result instead of adding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      trunc <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc   <= aligned;
        count <= CNT_W'(1);
        ovf   <= 1'b0;
        trunc <= trunc_now;
      end else begin
        acc   <= add_full[SUM_W-1:0];
        count <= count_inc;
        ovf   <= ovf | add_full[SUM_W];
        trunc <= trunc | trunc_now;
      end
    end
  end

  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;
  assign out_trunc = trunc;

endmodule

// File: tb/tb_shift_acc.sv
// Directed testbench for shift_acc with a frame-level arithmetic model and
// per-cycle comparison of handshake and held results.
module tb_shift_acc;

  localparam longint unsigned TWO34 = 64'h4_0000_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [4:0]  in_shift;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_sum;
  logic [5:0]  out_count;
  logic        out_ovf;
  logic        out_trunc;

  int errors = 0;
  int checks = 0;

  shift_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_trunc (out_trunc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame model: exact integer arithmetic, reduced mod 2^34 after each add.
  typedef struct {
    bit              hold;
    bit              open;
    longint unsigned sum;
    int              cnt;
    bit              ovf;
    bit              trunc;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t cur, bit v, bit [7:0] d, bit [4:0] s,
                                        bit l, bit r);
    model_t          nx;
    longint unsigned full;
    longint unsigned a;
    longint unsigned tot;
    bit              tr;
    nx = cur;
    if (v && !cur.hold) begin
      full = longint'(d) << s;
      a    = full % TWO34;
      tr   = (full >= TWO34);
      if (!cur.open) begin
        nx.sum   = a;
        nx.cnt   = 1;
        nx.ovf   = 1'b0;
        nx.trunc = tr;
      end else begin
        tot      = cur.sum + a;
        nx.ovf   = cur.ovf | (tot >= TWO34);
        nx.sum   = tot % TWO34;
        nx.cnt   = (cur.cnt < 63) ? cur.cnt + 1 : 63;
        nx.trunc = cur.trunc | tr;
      end
      nx.hold = l;
      nx.open = !l;
    end else if (cur.hold && r) begin
      nx.hold = 1'b0;
    end
    return nx;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{hold: 1'b0, open: 1'b0, sum: 0, cnt: 0, ovf: 1'b0, trunc: 1'b0};
    else     m <= model_step(m, in_valid, in_data, in_shift, in_last, out_ready);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake is compared every cycle; held data only while a result is presented.
  always @(negedge clk) begin
    if (!rst) begin
      check("model_out_valid", 64'(out_valid), 64'(m.hold));
      check("model_in_ready", 64'(in_ready), 64'(!m.hold));
      if (m.hold) begin
        check("model_out_sum", 64'(out_sum), m.sum);
        check("model_out_count", 64'(out_count), 64'(m.cnt));
        check("model_out_ovf", 64'(out_ovf), 64'(m.ovf));
        check("model_out_trunc", 64'(out_trunc), 64'(m.trunc));
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] d, input logic [4:0] s, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_shift = s;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("[TB] FAIL beat_accept_timeout: in_ready=%0b, expected 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [33:0] sum, input logic [5:0] cnt,
                              input logic ovf, input logic trunc);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_sum"}, 64'(out_sum), 64'(sum));
    check({name, "_count"}, 64'(out_count), 64'(cnt));
    check({name, "_ovf"}, 64'(out_ovf), 64'(ovf));
    check({name, "_trunc"}, 64'(out_trunc), 64'(trunc));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_valid"}, 64'(out_valid), 64'd0);
    check({name, "_ready"}, 64'(in_ready), 64'd1);
    check({name, "_sum"}, 64'(out_sum), 64'd0);
    check({name, "_count"}, 64'(out_count), 64'd0);
    check({name, "_flags"}, 64'({out_ovf, out_trunc}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    #2 rst = 1'b0;
    @(negedge clk);

    apply_stimulus(8'h01, 5'd0, 1'b0);
    apply_stimulus(8'h01, 5'd1, 1'b0);
    apply_stimulus(8'hFF, 5'd4, 1'b1);
    check_output("frame3", 34'h0_0000_0FF3, 6'd3, 1'b0, 1'b0);
    consume();

    apply_stimulus(8'h80, 5'd26, 1'b1);
    check_output("shift26", 34'h2_0000_0000, 6'd1, 1'b0, 1'b0);
    consume();
    apply_stimulus(8'h80, 5'd27, 1'b1);
    check_output("shift27", 34'h0, 6'd1, 1'b0, 1'b1);
    consume();

    apply_stimulus(8'hFF, 5'd26, 1'b0);
    apply_stimulus(8'hFF, 5'd26, 1'b1);
    check_output("wrap", 34'h3_F800_0000, 6'd2, 1'b1, 1'b0);
    consume();

    apply_stimulus(8'h10, 5'd0, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_shift = 5'd0;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check_output("stall", 34'h10, 6'd1, 1'b0, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_data   = 8'h02;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle_ready", 64'(in_ready), 64'd1);
    check("release_idle_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_output("after_release", 34'h2, 6'd1, 1'b0, 1'b0);
    consume();

    for (int i = 0; i < 70; i++) apply_stimulus(8'h01, 5'd0, i == 69);
    check_output("saturate", 34'd70, 6'd63, 1'b0, 1'b0);
    consume();

    apply_stimulus(8'h07, 5'd3, 1'b0);
    apply_stimulus(8'h09, 5'd1, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_state("abort_reset");
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("abort_no_result", 64'(out_valid), 64'd0);
    apply_stimulus(8'h05, 5'd0, 1'b1);
    check_output("after_abort", 34'd5, 6'd1, 1'b0, 1'b0);
    consume();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
